bp_out_wb_streamer: RTL and testbench

BP_OUT_WB_STREAMER -- requirements
Module: bp_out_wb_streamer

---
 rtl/bp_wb_pkg.sv | 23 ++
 rtl/bp_wb_fifo.sv | 48 ++++
 rtl/bp_out_wb_streamer.sv | 167 ++++++++++++++++
 tb/tb_bp_out_wb_streamer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_wb_pkg.sv
// Shared definitions for the output-buffer writeback streamer.
// HW_DSP_PE_COLS / HW_BP_OUT_BUF_DEPTH fall back to local defaults when the
// surrounding build does not provide them.

`ifndef HW_DSP_PE_COLS
`define HW_DSP_PE_COLS 15
`endif
`ifndef HW_BP_OUT_BUF_DEPTH
`define HW_BP_OUT_BUF_DEPTH 8
`endif

package bp_wb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int GROUPS = 4;
  localparam int BEAT_W = 64;

endpackage

// File: rtl/bp_wb_fifo.sv
// Synchronous skid FIFO holding {last, data} beats, with occupancy count.

module bp_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 65
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // storage write; contents need no reset since the head is qualified by empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/bp_out_wb_streamer.sv
// Streams output-buffer contents (address-outer, group-inner) onto an
// AXI-Stream master with credit-based read issue into a skid FIFO.
// Optional macro BP_WB_STALL_CNT_EN adds the wb_stall_cnt output.

module bp_out_wb_streamer
  import bp_wb_pkg::*;
#(
  parameter int BP_COLS          = `HW_DSP_PE_COLS,
  parameter int BP_OUT_BUF_DEPTH = `HW_BP_OUT_BUF_DEPTH,
  parameter int RD_LAT           = 2,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [BP_OUT_BUF_DEPTH-1:0]           cfg_addr_base,
  input  logic [BP_OUT_BUF_DEPTH:0]             cfg_addr_cnt,
  input  logic                                  cfg_buf_sel,
  output logic                                  busy,
  output logic                                  done,
  output logic [2:0]                            bp_out_buf_wb_en,
  output logic [BP_COLS*BP_OUT_BUF_DEPTH-1:0]   bp_out_buf_wb_addr,
  output logic                                  bp_out_buf_wb_sel,
  input  logic [BEAT_W-1:0]                     bp_out_wb_data,
  output logic [BEAT_W-1:0]                     m_axis_bp_out_wb_tdata,
  output logic                                  m_axis_bp_out_wb_tvalid,
  input  logic                                  m_axis_bp_out_wb_tready,
  output logic                                  m_axis_bp_out_wb_tlast
`ifdef BP_WB_STALL_CNT_EN
  ,
  output logic [31:0]                           wb_stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0]               CREDITS = (CW+1)'(FIFO_DEPTH);
  localparam logic [BP_OUT_BUF_DEPTH:0] ONE_ADDR = (BP_OUT_BUF_DEPTH+1)'(1);

  state_t                         state;
  logic [BP_OUT_BUF_DEPTH:0]      rem;
  logic [BP_OUT_BUF_DEPTH-1:0]    addr_q;
  logic [2:0]                     en_q;
  logic                           sel_q;
  logic [RD_LAT-1:0]              dl_vld;
  logic [RD_LAT-1:0]              dl_last;
  logic [CW-1:0]                  in_flight;
  logic [CW-1:0]                  fifo_count;
  logic [BEAT_W:0]                fifo_head;
  logic                           fifo_empty;
  logic                           fire;
  logic                           issue_last;
  logic                           push;
  logic                           pop;

  // The read presented on wb_en/addr is issued in any ISSUE cycle with credit;
  // without credit the presented read simply holds.
  assign fire       = (state == ISSUE) &&
                      (({1'b0, in_flight} + {1'b0, fifo_count}) < CREDITS);
  assign issue_last = (en_q == 3'(GROUPS-1)) && (rem == ONE_ADDR);
  assign push       = dl_vld[RD_LAT-1];
  assign pop        = m_axis_bp_out_wb_tvalid && m_axis_bp_out_wb_tready;

  // job FSM: latch configuration, walk addresses/groups, finish on final beat
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rem    <= '0;
      addr_q <= '0;
      en_q   <= '0;
      sel_q  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_addr_cnt != '0) begin
              state  <= ISSUE;
              rem    <= cfg_addr_cnt;
              addr_q <= cfg_addr_base;
              en_q   <= '0;
              sel_q  <= cfg_buf_sel;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (fire) begin
            if (issue_last) begin
              state <= DRAIN;
            end else if (en_q == 3'(GROUPS-1)) begin
              en_q   <= '0;
              addr_q <= addr_q + 1'b1;
              rem    <= rem - 1'b1;
            end else begin
              en_q <= en_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Leaving on the tlast handshake itself (nothing in flight, FIFO
          // about to empty) puts done in the cycle right after it.
          if (pop && fifo_head[BEAT_W]) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // read-latency delay line and in-flight credit accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_vld    <= '0;
      dl_last   <= '0;
      in_flight <= '0;
    end else begin
      dl_vld[0]  <= fire;
      dl_last[0] <= fire && issue_last;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        dl_vld[i]  <= dl_vld[i-1];
        dl_last[i] <= dl_last[i-1];
      end
      in_flight <= in_flight + CW'(fire) - CW'(push);
    end
  end

  bp_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BEAT_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({dl_last[RD_LAT-1], bp_out_wb_data}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign busy                    = (state != IDLE);
  assign bp_out_buf_wb_en        = en_q;
  assign bp_out_buf_wb_addr      = {BP_COLS{addr_q}};
  assign bp_out_buf_wb_sel       = sel_q;
  assign m_axis_bp_out_wb_tvalid = !fifo_empty;
  assign m_axis_bp_out_wb_tdata  = fifo_empty ? '0 : fifo_head[BEAT_W-1:0];
  assign m_axis_bp_out_wb_tlast  = !fifo_empty && fifo_head[BEAT_W];

`ifdef BP_WB_STALL_CNT_EN
  // saturating count of back-pressured cycles, cleared per accepted job
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_stall_cnt <= '0;
    end else if (start && (state == IDLE)) begin
      wb_stall_cnt <= '0;
    end else if (m_axis_bp_out_wb_tvalid && !m_axis_bp_out_wb_tready &&
                 (wb_stall_cnt != '1)) begin
      wb_stall_cnt <= wb_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_out_wb_streamer.sv
// Directed self-checking bench for bp_out_wb_streamer.
// Define BP_WB_STALL_CNT_EN to also check the stall counter.

module tb_bp_out_wb_streamer;

  localparam int COLS = 15;
  localparam int AW   = 8;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic [AW-1:0]        cfg_addr_base;
  logic [AW:0]          cfg_addr_cnt;
  logic                 cfg_buf_sel;
  logic                 busy;
  logic                 done;
  logic [2:0]           wb_en;
  logic [COLS*AW-1:0]   wb_addr;
  logic                 wb_sel;
  logic [63:0]          wb_data;
  logic [63:0]          tdata;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;
`ifdef BP_WB_STALL_CNT_EN
  logic [31:0]          wb_stall_cnt;
`endif

  bp_out_wb_streamer #(
    .BP_COLS          (COLS),
    .BP_OUT_BUF_DEPTH (AW),
    .RD_LAT           (2),
    .FIFO_DEPTH       (4)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .start                   (start),
    .cfg_addr_base           (cfg_addr_base),
    .cfg_addr_cnt            (cfg_addr_cnt),
    .cfg_buf_sel             (cfg_buf_sel),
    .busy                    (busy),
    .done                    (done),
    .bp_out_buf_wb_en        (wb_en),
    .bp_out_buf_wb_addr      (wb_addr),
    .bp_out_buf_wb_sel       (wb_sel),
    .bp_out_wb_data          (wb_data),
    .m_axis_bp_out_wb_tdata  (tdata),
    .m_axis_bp_out_wb_tvalid (tvalid),
    .m_axis_bp_out_wb_tready (tready),
    .m_axis_bp_out_wb_tlast  (tlast)
`ifdef BP_WB_STALL_CNT_EN
    ,
    .wb_stall_cnt            (wb_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // buffer model: tagged word per (group, address); group 3 has zero top bits
  function automatic logic [63:0] mk_data(input logic [2:0] en, input logic [7:0] a);
    logic [15:0] hi;
    hi = (en == 3'd3) ? 16'h0000 : 16'hA5C3;
    return {hi, a, 5'b0, en, 32'h1357_9BDF};
  endfunction

  // two-cycle read latency (buffer read + core register)
  logic [63:0] d1, d2;
  always @(posedge clk) begin
    d1 <= mk_data(wb_en, wb_addr[AW-1:0]);
    d2 <= d1;
  end
  assign wb_data = d2;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int          cyc;
  logic [63:0] beat_d[$];
  logic        beat_l[$];
  logic [10:0] pairs[$];
  int          first_hs, last_hs, done_cyc, done_n, busy_n, tv_n;
  int          stable_err, sel_err;
  logic        prev_stall, prev_l, cur_sel;
  logic [63:0] prev_d;

  task automatic clear_job();
    beat_d.delete(); beat_l.delete(); pairs.delete();
    first_hs = -1; last_hs = -1; done_cyc = -1;
    done_n = 0; busy_n = 0; tv_n = 0; stable_err = 0; sel_err = 0;
    prev_stall = 1'b0;
  endtask

  // drive tready for the coming edge, observe current cycle, advance one cycle
  task automatic tick(input logic rdy);
    logic [10:0] p;
    tready = rdy;
    if (prev_stall && !(tvalid && tdata == prev_d && tlast == prev_l)) stable_err++;
    if (tvalid) tv_n++;
    if (tvalid && rdy) begin
      if (beat_d.size() == 0) first_hs = cyc;
      beat_d.push_back(tdata);
      beat_l.push_back(tlast);
      if (tlast) last_hs = cyc;
    end
    if (done) begin done_n++; done_cyc = cyc; end
    if (busy) begin
      busy_n++;
      if (wb_sel !== cur_sel) sel_err++;
      p = {wb_en, wb_addr[AW-1:0]};
      if (pairs.size() == 0 || pairs[$] != p) pairs.push_back(p);
    end
    prev_stall = tvalid && !rdy;
    prev_d = tdata;
    prev_l = tlast;
    cyc++;
    @(negedge clk);
  endtask

  // mode 0: tready high, 1: toggle 0/1, 2: low for 20 cycles then high
  task automatic run_job(input logic [7:0] base, input int cnt, input logic sel,
                         input int mode, input int restart_k);
    int k, post, start_cyc, held_n;
    logic [10:0] p10, p20;
    logic [7:0] a;
    clear_job();
    cur_sel = sel;
    cfg_addr_base = base;
    cfg_addr_cnt  = 9'(cnt);
    cfg_buf_sel   = sel;
    start = 1'b1;
    start_cyc = cyc;
    k = 0; post = 0; held_n = 0; p10 = '0; p20 = '0;
    while (k < 300 && post < 3) begin
      if (k == 1) check("addr_cols", wb_addr, {COLS{base}});
      if (k == 10) p10 = {wb_en, wb_addr[AW-1:0]};
      if (k == 20) begin p20 = {wb_en, wb_addr[AW-1:0]}; held_n = pairs.size(); end
      if (k == restart_k) begin start = 1'b1; cfg_addr_cnt = 9'd3; end
      else if (k > 0) start = 1'b0;
      case (mode)
        1:       tick(k[0]);
        2:       tick(k > 20);
        default: tick(1'b1);
      endcase
      k++;
      if (done_n > 0) post++;
    end
    start = 1'b0;
    check("n_beats", beat_d.size(), 4*cnt);
    for (int i = 0; i < beat_d.size() && i < 4*cnt; i++) begin
      a = 8'(base + 8'(i/4));
      check("beat_data", beat_d[i], mk_data(3'(i%4), a));
      check("beat_last", beat_l[i], (i == 4*cnt-1));
    end
    check("n_reads", pairs.size(), 4*cnt);
    for (int i = 0; i < pairs.size() && i < 4*cnt; i++) begin
      a = 8'(base + 8'(i/4));
      check("read_order", pairs[i], {3'(i%4), a});
    end
    check("done_n", done_n, 1);
    check("done_after_tlast", done_cyc - last_hs, 1);
    check("first_lat_ge3", (first_hs - start_cyc) >= 3, 1);
    check("stable_on_stall", stable_err, 0);
    check("wb_sel", sel_err, 0);
    if (mode == 0) check("back_to_back", last_hs - first_hs, 4*cnt-1);
    if (mode == 2) begin
      // four reads fill the credit; the fifth (group 0 of base+1) waits presented
      check("stall_reads", held_n, 5);
      check("stall_hold_10", p10, {3'd0, 8'(base + 8'd1)});
      check("stall_hold_20", p20, {3'd0, 8'(base + 8'd1)});
    end
  endtask

  initial begin
    int k;
    cyc = 0;
    rst = 1'b1; start = 1'b0; tready = 1'b0;
    cfg_addr_base = '0; cfg_addr_cnt = '0; cfg_buf_sel = 1'b0; cur_sel = 1'b0;
    clear_job();
    @(negedge clk);
    tick(1'b0); tick(1'b0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_wb_en", wb_en, 0);
    check("rst_wb_addr", wb_addr, 0);
    rst = 1'b0;
    tick(1'b0);

    // basic job, wrap-around, back-pressure patterns
    run_job(8'd0,   2, 1'b0, 0, -1);
    run_job(8'd255, 2, 1'b1, 0, -1);
    run_job(8'd20,  4, 1'b0, 1, -1);
`ifdef BP_WB_STALL_CNT_EN
    check("stall_cnt", wb_stall_cnt, 32'd16);
`endif
    run_job(8'd10,  3, 1'b1, 2, -1);

    // zero-length job
    clear_job();
    cfg_addr_cnt = '0;
    start = 1'b1;
    k = cyc;
    tick(1'b1);
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b1);
    check("cnt0_done_n", done_n, 1);
    check("cnt0_done_lat", done_cyc - k, 1);
    check("cnt0_busy", busy_n, 0);
    check("cnt0_tvalid", tv_n, 0);

    // start while busy is ignored
    run_job(8'd40, 2, 1'b0, 0, 5);

    // reset in the middle of a job
    clear_job();
    cfg_addr_base = 8'd0; cfg_addr_cnt = 9'd4; cfg_buf_sel = 1'b1; cur_sel = 1'b1;
    start = 1'b1;
    tick(1'b1);
    start = 1'b0;
    k = 0;
    while (beat_d.size() < 5 && k < 50) begin tick(1'b1); k++; end
    check("pre_rst_beats", beat_d.size(), 5);
    rst = 1'b1;
    tick(1'b0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_tlast", tlast, 0);
    check("mid_rst_tdata", tdata, 0);
    check("mid_rst_wb_en", wb_en, 0);
    check("mid_rst_wb_addr", wb_addr, 0);
    check("mid_rst_wb_sel", wb_sel, 0);
    rst = 1'b0;
    tv_n = 0; done_n = 0;
    for (int i = 0; i < 10; i++) tick(1'b1);
    check("post_rst_no_done", done_n, 0);
    check("post_rst_no_tvalid", tv_n, 0);
    run_job(8'd5, 1, 1'b0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
